// File: rtl/spi_pkg.sv
// Shared register map, CTRL/STATUS bit layout and sequencer state encoding
// for the SPI master and its request sequencer.
package spi_pkg;

    localparam logic [31:0] SPI_CTRL_OFS   = 32'h0;
    localparam logic [31:0] SPI_DATA_OFS   = 32'h4;
    localparam logic [31:0] SPI_STATUS_OFS = 32'h8;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_CPOL    = 1;
    localparam int CTRL_CPHA    = 2;
    localparam int CTRL_SS      = 3;
    localparam int CTRL_DIV_LSB = 8;
    localparam int CTRL_DIV_MSB = 15;

    localparam int STATUS_BUSY = 0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        POLL,
        READ,
        EMIT,
        DESEL
    } seq_state_e;

    function automatic logic [31:0] ctrl_word(input logic [7:0] div,
                                              input logic       cpha,
                                              input logic       cpol,
                                              input logic       ss,
                                              input logic       en);
        logic [31:0] w;
        w = '0;
        w[CTRL_DIV_MSB:CTRL_DIV_LSB] = div;
        w[CTRL_SS]   = ss;
        w[CTRL_CPHA] = cpha;
        w[CTRL_CPOL] = cpol;
        w[CTRL_EN]   = en;
        return w;
    endfunction

    // Header byte order on the wire: command, then address MSB first.
    function automatic logic [7:0] hdr_byte(input logic [7:0]  cmd,
                                            input logic [23:0] addr,
                                            input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = cmd;
            2'd1:    b = addr[23:16];
            2'd2:    b = addr[15:8];
            default: b = addr[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_xfer_seq.sv
// Sequences one cmd+addr+N-byte read as SPI master register accesses.
// Latency: per byte LOAD+START+GUARD wait+poll of the SPI master busy flag, plus READ/EMIT in the read phase.
// Backpressure: req_ready_o only in IDLE; rx byte held in EMIT until rx_ready_i, SPI clock idle meanwhile.
module spi_xfer_seq
    import spi_pkg::*;
#(
    parameter logic [7:0] DIV   = 8'd1,
    parameter logic       CPOL  = 1'b0,
    parameter logic       CPHA  = 1'b0,
    parameter int         LEN_W = 8,
    parameter int         GUARD = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [7:0]       req_cmd_i,
    input  logic [23:0]      req_addr_i,
    input  logic [LEN_W-1:0] req_len_i,
    output logic             rx_valid_o,
    output logic [7:0]       rx_data_o,
    input  logic             rx_ready_i,
    output logic             busy_o,
    output logic [31:0]      spi_data_o,
    output logic [31:0]      spi_addr_o,
    output logic             spi_we_o,
    input  logic [31:0]      spi_data_i
);

    localparam logic [31:0] CTRL_START = ctrl_word(DIV, CPHA, CPOL, 1'b1, 1'b1);
    localparam logic [31:0] CTRL_DESEL = ctrl_word(DIV, CPHA, CPOL, 1'b0, 1'b0);
    localparam int          GW         = (GUARD > 2) ? $clog2(GUARD) : 1;

    seq_state_e       state;
    logic [7:0]       cmd_q;
    logic [23:0]      addr_q;
    logic [LEN_W-1:0] rd_cnt;
    logic [1:0]       hdr_cnt;
    logic             in_hdr;
    logic [GW-1:0]    wait_cnt;

    // Only the low byte of DATA and the busy bit of STATUS carry information.
    logic spi_rd_unused;
    assign spi_rd_unused = ^spi_data_i[31:8];

    // Bus outputs are registered: each transition sets the values for the state being entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            rx_valid_o  <= 1'b0;
            rx_data_o   <= 8'h00;
            spi_we_o    <= 1'b0;
            spi_addr_o  <= SPI_STATUS_OFS;
            spi_data_o  <= 32'h0;
            cmd_q       <= 8'h00;
            addr_q      <= 24'h0;
            rd_cnt      <= '0;
            hdr_cnt     <= 2'd0;
            in_hdr      <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            spi_we_o   <= 1'b0;
            spi_addr_o <= SPI_STATUS_OFS;
            spi_data_o <= 32'h0;

            case (state)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        cmd_q       <= req_cmd_i;
                        addr_q      <= req_addr_i;
                        rd_cnt      <= req_len_i;
                        hdr_cnt     <= 2'd0;
                        in_hdr      <= 1'b1;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        spi_we_o    <= 1'b1;
                        spi_addr_o  <= SPI_DATA_OFS;
                        spi_data_o  <= {24'h0, req_cmd_i};
                        state       <= LOAD;
                    end
                end

                LOAD: begin
                    spi_we_o   <= 1'b1;
                    spi_addr_o <= SPI_CTRL_OFS;
                    spi_data_o <= CTRL_START;
                    state      <= START;
                end

                START: begin
                    wait_cnt <= GW'(GUARD - 1);
                    state    <= WAIT;
                end

                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= POLL;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                POLL: begin
                    if (!spi_data_i[STATUS_BUSY]) begin
                        if (!in_hdr) begin
                            spi_addr_o <= SPI_DATA_OFS;
                            state      <= READ;
                        end else if (hdr_cnt != 2'd3) begin
                            hdr_cnt    <= hdr_cnt + 2'd1;
                            spi_we_o   <= 1'b1;
                            spi_addr_o <= SPI_DATA_OFS;
                            spi_data_o <= {24'h0, hdr_byte(cmd_q, addr_q, hdr_cnt + 2'd1)};
                            state      <= LOAD;
                        end else if (rd_cnt == '0) begin
                            in_hdr     <= 1'b0;
                            spi_we_o   <= 1'b1;
                            spi_addr_o <= SPI_CTRL_OFS;
                            spi_data_o <= CTRL_DESEL;
                            state      <= DESEL;
                        end else begin
                            // First dummy byte of the read phase.
                            in_hdr     <= 1'b0;
                            spi_we_o   <= 1'b1;
                            spi_addr_o <= SPI_DATA_OFS;
                            state      <= LOAD;
                        end
                    end
                end

                READ: begin
                    rx_data_o  <= spi_data_i[7:0];
                    rx_valid_o <= 1'b1;
                    state      <= EMIT;
                end

                EMIT: begin
                    if (rx_ready_i) begin
                        rx_valid_o <= 1'b0;
                        rd_cnt     <= rd_cnt - 1'b1;
                        spi_we_o   <= 1'b1;
                        if (rd_cnt == LEN_W'(1)) begin
                            spi_addr_o <= SPI_CTRL_OFS;
                            spi_data_o <= CTRL_DESEL;
                            state      <= DESEL;
                        end else begin
                            spi_addr_o <= SPI_DATA_OFS;
                            state      <= LOAD;
                        end
                    end
                end

                DESEL: begin
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                    state       <= IDLE;
                end

                default: begin
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_xfer_seq.md
Name: spi_xfer_seq

Overview:
- Upstream sequencer for the SPI master peripheral. Turns one host request (command byte, 24-bit address, N read bytes) into a sequence of register accesses on the SPI master's bus port.
- Register accesses: write SPI_DATA, write SPI_CTRL with enable set, poll SPI_STATUS, read SPI_DATA.
- Returned bytes go out on a valid/ready stream.
- Sits between a flash-read / boot-copy client and the SPI master, replacing software polling.

Parameters:
- DIV, 8'd1, value written to SPI_CTRL[15:8] (SPI clock divider).
- CPOL, 1'b0, value written to SPI_CTRL[1].
- CPHA, 1'b0, value written to SPI_CTRL[2].
- LEN_W, 8, width of read-length field.
- GUARD, 3, cycles to wait after the CTRL start write before polling begins.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  high only in IDLE
- req_cmd_i  in  8  SPI command byte
- req_addr_i  in  24  flash address, sent MSB byte first
- req_len_i  in  LEN_W  number of bytes to read; 0 = command+address only
- rx_valid_o  out  1  read byte valid
- rx_data_o  out  8  read byte
- rx_ready_i  in  1  consumer accepts byte
- busy_o  out  1  high whenever state != IDLE
- spi_data_o  out  32  write data to SPI master
- spi_addr_o  out  32  register offset to SPI master (0x0 CTRL, 0x4 DATA, 0x8 STATUS)
- spi_we_o  out  1  write enable to SPI master
- spi_data_i  in  32  combinational read data from SPI master

Behaviour:
- Clock and reset: single clock clk_i; asynchronous active-low reset rst_ni.
- Reset values: state=IDLE, req_ready_o=1, rx_valid_o=0, rx_data_o=0, busy_o=0, spi_we_o=0, spi_addr_o=0x8, spi_data_o=0, all counters 0.
- Handshake: request accepted on req_valid_i && req_ready_o. cmd/addr/len are latched that cycle and the inputs are ignored afterwards.
- Byte stream per transfer: cmd, addr[23:16], addr[15:8], addr[7:0] (header, hdr_cnt 0..3), then req_len bytes of 0x00 (read phase, rd_cnt counts down).
- IDLE: on accept, go to LOAD.
- LOAD (1 cycle): we=1, addr=0x4, data={24'h0, current byte}. Go to START.
- START (1 cycle): we=1, addr=0x0, data={16'h0, DIV, 4'b0, 1'b1 (ss), CPHA, CPOL, 1'b1 (en)}. Go to WAIT.
- WAIT (GUARD cycles): we=0, addr=0x8. Covers the master's ctrl->en->status pipeline (status[0] rises 3 cycles after the START write). Go to POLL.
- POLL: we=0, addr=0x8, stay while spi_data_i[0]==1. On 0:
  - header byte with more header left -> LOAD;
  - last header byte and len==0 -> DESEL;
  - last header byte and len>0 -> LOAD;
  - read-phase byte -> READ.
- READ (1 cycle): we=0, addr=0x4; register spi_data_i[7:0] into rx_data_o, set rx_valid_o. Go to EMIT.
- EMIT: hold rx_valid_o/rx_data_o stable until rx_ready_i. On handshake, clear rx_valid_o and decrement rd_cnt. If rd_cnt reaches 0 go to DESEL, else LOAD. SPI clock stays idle while stalled; ss stays asserted.
- DESEL (1 cycle): we=1, addr=0x0, data={16'h0, DIV, 4'b0, 1'b0, CPHA, CPOL, 1'b0}. Releases chip select. Go to IDLE.
- Header rx bytes are discarded and never appear on rx_valid_o.
- Never write while the master is busy. Only LOAD, START and DESEL drive we=1.
- Outside write states, spi_addr_o defaults to 0x8 and spi_data_o to 0.
- req_len of all-ones (255 at default) is legal: 255 read bytes, no wrap.
- rx_ready_i held high: EMIT lasts exactly 1 cycle.
- Reset asserted mid-transfer: immediate return to reset values; any partial rx byte is dropped. The master shares rst_ni, so ss is released by the master's own reset.
- req_valid_i while busy: ignored, since req_ready_o=0.

Decomposition:
- Shared spi_pkg holds:
  - register offsets SPI_CTRL_OFS=0x0, SPI_DATA_OFS=0x4, SPI_STATUS_OFS=0x8;
  - CTRL bit positions (EN=0, CPOL=1, CPHA=2, SS=3, DIV=15:8);
  - STATUS_BUSY=0;
  - state enum seq_state_e {IDLE, LOAD, START, WAIT, POLL, READ, EMIT, DESEL}.
- Single module, no sub-module. The byte-mux and counters are small enough to stay inline.

Test Plan:
- Bench: spi_xfer_seq connected to the real SPI master plus a behavioural flash model (cmd 0x03) returning byte = addr[7:0].
- Request cmd=0x03, addr=0x00_1234, len=4, rx_ready_i=1 -> rx stream 0x34,0x35,0x36,0x37; exactly 8 SPI_DATA writes; ss low for the whole transfer, high after DESEL; busy_o falls one cycle after the DESEL write.
- len=0, cmd=0x06 -> 4 bytes shifted out on MOSI (06 00 12 34), rx_valid_o never asserted, returns to IDLE with req_ready_o=1.
- len=3 with rx_ready_i low for 20 cycles on the 2nd byte -> rx_data_o stable and rx_valid_o high throughout; no SPI clock edges during the stall; all 3 bytes correct afterwards.
- DIV=0 vs DIV=3 -> POLL duration scales (8x input clock per bit for DIV=3); no CTRL/DATA write ever observed while SPI_STATUS[0]==1 (assertion).
- Assert rst_ni low during the 2nd read byte's POLL -> all outputs at reset values asynchronously; after release a new request len=1 completes correctly with the proper byte.
